// File: rtl/rx_if_cfg_sequencer_if.sv
// Table lookup and 3-wire serial bus bundle between the RX IF config sequencer and its table/chip.
// master = sequencer side, slave = table + chip (or bench) side.
interface rx_if_cfg_sequencer_if;
  logic       start;
  logic [5:0] idx;
  logic [4:0] addr;
  logic [7:0] data;
  logic       sclk;
  logic       sdata;
  logic       sen_n;
  logic       busy;
  logic       done;

  modport master (
    input  start, addr, data,
    output idx, sclk, sdata, sen_n, busy, done
  );

  modport slave (
    output start, addr, data,
    input  idx, sclk, sdata, sen_n, busy, done
  );
endinterface

// File: rtl/rx_if_cfg_sequencer.sv
// Walks cfg table idx 0..LAST_IDX, sending {3'b0,addr,data} MSB-first on sclk/sdata/sen_n; CFG_SKIP_BLANK_EN skips all-zero entries.
// Latency: start at edge T -> LOAD in cycle T+1, sen_n low from edge T+2; each entry costs 1+32*CLK_DIV+GAP_CYC cycles.
// Backpressure: none; start while busy is dropped, not queued.
module rx_if_cfg_sequencer #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_CYC  = 8,
  parameter int LAST_IDX = 63
) (
  input logic                   clk,
  input logic                   nrst,
  rx_if_cfg_sequencer_if.master bus
);

  localparam int CMAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [5:0]    idx_q, idx_nxt;
  logic [15:0]   sr, sr_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sclk_q, sclk_nxt;
  logic          sdata_q, sdata_nxt;
  logic          sen_n_q, sen_n_nxt;
  logic          done_q, done_nxt;

  logic [15:0]   entry;
  logic          cnt_wrap, last_bit, gap_end, at_last, blank;

  assign entry    = {3'b000, bus.addr, bus.data};
  assign cnt_wrap = (cnt == CW'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == 4'd15);
  assign gap_end  = (cnt == CW'(GAP_CYC - 1));
  assign at_last  = (idx_q == 6'(LAST_IDX));

`ifdef CFG_SKIP_BLANK_EN
  assign blank = (bus.addr == 5'd0) && (bus.data == 8'd0);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      idx_q   <= '0;
      sr      <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      sen_n_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx_q   <= idx_nxt;
      sr      <= sr_nxt;
      bit_cnt <= bit_cnt_nxt;
      cnt     <= cnt_nxt;
      sclk_q  <= sclk_nxt;
      sdata_q <= sdata_nxt;
      sen_n_q <= sen_n_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    if (blank) state_nxt = at_last ? FIN : LOAD;
               else       state_nxt = SHIFT;
      SHIFT:   if (cnt_wrap && sclk_q && last_bit) state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = at_last ? FIN : LOAD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idx_nxt     = idx_q;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    cnt_nxt     = cnt;
    sclk_nxt    = sclk_q;
    sdata_nxt   = sdata_q;
    sen_n_nxt   = sen_n_q;
    done_nxt    = done_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          idx_nxt  = '0;
          done_nxt = 1'b0;
        end
      end
      LOAD: begin
        if (blank) begin
          if (!at_last) idx_nxt = idx_q + 6'd1;
        end else begin
          sr_nxt      = entry;
          sdata_nxt   = entry[15];
          sen_n_nxt   = 1'b0;
          bit_cnt_nxt = '0;
          cnt_nxt     = '0;
        end
      end
      SHIFT: begin
        if (cnt_wrap) begin
          cnt_nxt  = '0;
          sclk_nxt = ~sclk_q;
          // Data only moves on the falling toggle, so it is stable around each rising edge.
          if (sclk_q) begin
            if (last_bit) begin
              sen_n_nxt = 1'b1;
              sdata_nxt = 1'b0;
            end else begin
              sr_nxt      = {sr[14:0], 1'b0};
              sdata_nxt   = sr[14];
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (gap_end) begin
          cnt_nxt = '0;
          if (!at_last) idx_nxt = idx_q + 6'd1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: ;
    endcase
    if (state_nxt == FIN) done_nxt = 1'b1;
  end

  always_comb begin
    bus.idx   = idx_q;
    bus.sclk  = sclk_q;
    bus.sdata = sdata_q;
    bus.sen_n = sen_n_q;
    bus.busy  = (state == LOAD) || (state == SHIFT) || (state == GAP);
    bus.done  = done_q;
  end

endmodule

// File: doc/rx_if_cfg_sequencer.md
Name: rx_if_cfg_sequencer

Overview:
- Reads the RX IF configuration table one entry at a time: drives `idx` and samples the returned `addr`/`data`.
- Serializes each entry as a 16-bit write frame on a 3-wire serial bus (`sclk`/`sdata`/`sen_n`) to the RX IF chip.
- Starts on a `start` pulse and walks `idx` 0..LAST_IDX. It is the master side that consumes the table and programs the chip's paged registers.

Parameters:
- CLK_DIV, 4, system clocks per `sclk` half-period (>=1).
- GAP_CYC, 8, system clocks `sen_n` is held high between frames (>=1).
- LAST_IDX, 63, final table index sent (0..63).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to run the full sequence.
- idx  out  6  table index presented to the register table.
- addr  in  5  table register address for the current `idx` (combinational return).
- data  in  8  table register data for the current `idx` (combinational return).
- sclk  out  1  serial clock; idles low; chip samples on the rising edge.
- sdata  out  1  serial data, MSB first.
- sen_n  out  1  frame enable, active-low.
- busy  out  1  high while a sequence is in progress.
- done  out  1  high after a sequence completes; held until the next accepted `start` or reset.

Behaviour:
- Reset (nrst=0 at a clk edge), including mid-operation: next edge gives state=IDLE, idx=0, sclk=0, sdata=0, sen_n=1, busy=0, done=0, counters=0. Any partial frame is abandoned with `sen_n` high.
- States: IDLE, LOAD, SHIFT, GAP, FIN.
- IDLE: outputs idle. `start`=1 gives next state LOAD with idx=0, busy=1, done=0.
- LOAD (1 cycle):
  - Latches shift register `sr` = {3'b000, addr, data} (16 bits) from the current `idx`.
  - Next: SHIFT with sen_n=0, sdata=sr[15], bit counter=0, div counter=0.
- SHIFT:
  - Div counter counts 0..CLK_DIV-1, then wraps and toggles `sclk`.
  - On each `sclk` falling toggle: shift `sr` left and update `sdata` to the new MSB; bit counter +1.
  - After the falling toggle that ends bit 15: sclk=0, sen_n=1, sdata=0; next state GAP.
  - Each bit is 2*CLK_DIV cycles; `sdata` is stable CLK_DIV cycles before and after each rising edge.
- GAP:
  - Holds `sen_n` high for GAP_CYC cycles.
  - Then, if idx==LAST_IDX, next state is FIN; otherwise idx<=idx+1 and next state is LOAD.
- FIN (1 cycle): busy=0, done=1; next state IDLE.
- Per-entry cost: 1 + 32*CLK_DIV + GAP_CYC cycles. Full run: (LAST_IDX+1) times that, plus 1 FIN cycle.
- Latency: `start` sampled at edge T gives LOAD during cycle T+1; sen_n=0 from edge T+2.
- `start` while busy=1 is ignored; it is not queued.
- `start` together with done=1 in IDLE clears done and begins a new run.
- `idx` changes only on the GAP→LOAD transition (or to 0 on start/reset), so `addr`/`data` are settled by LOAD.
- `idx` never exceeds LAST_IDX and never wraps. LAST_IDX=0 sends exactly one frame.
- Frames are not reordered or merged. Page-select entries (addr 5'h1F) are sent like any other entry; page handling lives in the chip.

Optional Feature:
- Macro: CFG_SKIP_BLANK_EN.
- Defined: in LOAD, an entry with addr==0 and data==0 is skipped.
  - No frame is sent and `sen_n` stays high.
  - Proceeds directly with the GAP exit decision: FIN if idx==LAST_IDX, otherwise idx+1 and LOAD.
  - A skipped entry costs 1 cycle.
- Undefined: every index 0..LAST_IDX is sent, including all-zero entries.

Test Plan:
- Reset/idle: hold nrst=0 for 3 cycles, then release → idx=0, sclk=0, sdata=0, sen_n=1, busy=0, done=0, stable with no `start`.
- Three-entry run, CLK_DIV=2, GAP_CYC=4, LAST_IDX=2, table {1F/00, 00/F1, 01/54}:
  - Serial monitor captures exactly 3 frames: 0x1F00, 0x00F1, 0x0154, MSB first, sampled on `sclk` rising edges.
  - busy is high for 207 cycles, then done=1.
- Timing: CLK_DIV=3 → each `sclk` high and low phase is 3 cycles; `sen_n` falls 1 cycle after LOAD; GAP_CYC cycles of `sen_n` high between frames.
- Busy start / restart:
  - Pulse `start` mid-frame → the sequence is unaffected (same frame count).
  - Pulse `start` after done=1 → done=0 next cycle and the sequence repeats identically.
- Reset mid-frame: assert nrst=0 at bit 7 of frame 1 → next edge sen_n=1, sclk=0, idx=0, busy=0; a later `start` sends from idx 0.
- CFG_SKIP_BLANK_EN defined, LAST_IDX=63, entries 60-62 all-zero → 61 frames sent, idx goes 59→60→61→62→63 with no `sen_n` activity for 60-62, and the frame for 63 is 0x0201.
